ethernet_frame_generator: RTL and testbench
===========================================

Name: ethernet_frame_generator

Overview:
Byte-wide Ethernet-style frame source for MII/GMII-type verification benches. On request it emits a frame made of a preamble, an SFD, a fixed-length incrementing payload and an end-of-frame byte. Frames are separated by a minimum inter-frame idle gap. It drives an 8-bit data bus, a frame-valid control strobe and a forwarded transmit clock toward the DUT's MII receive side.

Parameters:
IDLE_CYCLES, 12, minimum idle cycles before a frame may start (>=1)
PREAMBLE_CYCLES, 7, number of preamble bytes (>=1)
SFD_CYCLES, 1, number of SFD bytes (>=1)
DATA_CYCLES, 46, number of payload bytes (>=1)
IDLE_CODE, 8'h00, tx_data value while idle
PREAMBLE_CODE, 8'h55, tx_data value during preamble
SFD_CODE, 8'hD5, tx_data value during SFD
EOF_CODE, 8'h00, tx_data value for the single end-of-frame cycle

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level-sensitive frame request, sampled only in IDLE
tx_data  output  8  transmitted byte
tx_ctrl  output  1  1 = frame byte (preamble/SFD/payload), 0 = idle/EOF
tx_clk  output  1  forwarded transmit clock, combinationally equal to clk

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, while asserted:
  - state = IDLE, tx_data = IDLE_CODE, tx_ctrl = 0.
  - Idle counter = 0; payload counter = 0.
- tx_clk = clk at all times, including during reset.
- FSM: IDLE -> PREAMBLE -> SFD -> DATA -> EOF -> IDLE.
- Outputs are registered and updated on the same edge as the state, so the outputs always reflect the current state.
- IDLE:
  - tx_data = IDLE_CODE, tx_ctrl = 0.
  - Idle counter increments each cycle and saturates at IDLE_CYCLES.
  - The counter is cleared on entry to IDLE and by reset.
  - Transition to PREAMBLE happens at the edge where start = 1 and the counter shows at least IDLE_CYCLES completed idle cycles, counting the current one.
  - Idle therefore lasts at least IDLE_CYCLES cycles, after reset as well as between frames.
- PREAMBLE: exactly PREAMBLE_CYCLES cycles; tx_data = PREAMBLE_CODE, tx_ctrl = 1.
- SFD: exactly SFD_CYCLES cycles; tx_data = SFD_CODE, tx_ctrl = 1.
- DATA:
  - Exactly DATA_CYCLES cycles, tx_ctrl = 1.
  - tx_data = payload index 0,1,2,... truncated to 8 bits (wraps 8'hFF -> 8'h00 when DATA_CYCLES > 256).
  - The index restarts at 0 for every frame.
- EOF: exactly 1 cycle; tx_data = EOF_CODE, tx_ctrl = 0; then IDLE.
- Frame length is PREAMBLE_CYCLES + SFD_CYCLES + DATA_CYCLES + 1 cycles (55 with defaults).
- start is ignored outside IDLE. Deasserting it mid-frame never truncates the frame, and a pulse during a frame is not queued.
- start held high continuously gives back-to-back frames separated by exactly IDLE_CYCLES idle cycles.
- Reset asserted mid-frame aborts the frame immediately (asynchronously) to IDLE values. After release, a fresh IDLE_CYCLES gap is required.
- All phase counters are sized for their parameter with $clog2(max+1) bits. No overflow may occur for any legal parameter value.

Test Plan:
1. Reset then idle:
   - Stimulus: assert reset for 2 cycles, keep start = 0 for 30 cycles.
   - Response: tx_data = 8'h00 and tx_ctrl = 0 throughout; tx_clk tracks clk.
2. Single frame, defaults:
   - Stimulus: release reset, raise start 2 cycles later, drop it after 20 cycles.
   - Response, once 12 idle cycles have elapsed:
     - 7 x 8'h55 then 1 x 8'hD5, with tx_ctrl = 1;
     - payload 8'h00..8'h2D (46 bytes), with tx_ctrl = 1;
     - one 8'h00 with tx_ctrl = 0;
     - then idle with no second frame.
3. Back-to-back frames:
   - Stimulus: hold start = 1 continuously.
   - Response: frames of 55 cycles separated by exactly 12 idle cycles; the payload restarts at 8'h00 in each frame.
4. Gap enforcement:
   - Stimulus: pulse start for 1 cycle at idle cycle 5 after a frame, then again at idle cycle 12.
   - Response: the first pulse is ignored; the second starts a frame on the next cycle.
5. Reset mid-frame:
   - Stimulus: assert reset during payload byte 20.
   - Response: immediately tx_data = 8'h00, tx_ctrl = 0. After release with start = 1, the next frame begins only after 12 idle cycles and its payload begins at 8'h00.
6. Parameter override:
   - Stimulus: DATA_CYCLES = 300, PREAMBLE_CYCLES = 3, PREAMBLE_CODE = 8'hAA.
   - Response: 3 x 8'hAA, then 8'hD5, then payload 8'h00..8'hFF followed by 8'h00..8'h2B, then EOF.

Source files
------------

// File: rtl/ethernet_frame_generator.sv
// Byte-wide Ethernet-style frame source: idle gap, preamble, SFD,
// incrementing payload and a single end-of-frame byte, repeated on request.
module ethernet_frame_generator #(
    parameter int unsigned IDLE_CYCLES     = 12,
    parameter int unsigned PREAMBLE_CYCLES = 7,
    parameter int unsigned SFD_CYCLES      = 1,
    parameter int unsigned DATA_CYCLES     = 46,
    parameter logic [7:0]  IDLE_CODE       = 8'h00,
    parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
    parameter logic [7:0]  SFD_CODE        = 8'hD5,
    parameter logic [7:0]  EOF_CODE        = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       tx_ctrl,
    output logic       tx_clk
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned PW = $clog2(PREAMBLE_CYCLES + 1);
    localparam int unsigned SW = $clog2(SFD_CYCLES + 1);
    localparam int unsigned DW = $clog2(DATA_CYCLES + 1);

    // Idle counter holds completed idle cycles; the current cycle completes
    // the gap when the counter already shows IDLE_CYCLES-1.
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_CYCLES - 1);
    localparam logic [SW-1:0] SFD_LAST  = SW'(SFD_CYCLES - 1);
    localparam logic [DW-1:0] DATA_LAST = DW'(DATA_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_EOF
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idle_cnt;
    logic [IW-1:0] w_idle_cnt_nxt;
    logic [PW-1:0] r_pre_cnt;
    logic [PW-1:0] w_pre_cnt_nxt;
    logic [SW-1:0] r_sfd_cnt;
    logic [SW-1:0] w_sfd_cnt_nxt;
    logic [DW-1:0] r_data_cnt;
    logic [DW-1:0] w_data_cnt_nxt;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    logic          r_tx_ctrl;
    logic          w_tx_ctrl_nxt;

    assign tx_clk  = clk;
    assign tx_data = r_tx_data;
    assign tx_ctrl = r_tx_ctrl;

    // State, phase counters and registered outputs, all on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idle_cnt <= '0;
            r_pre_cnt  <= '0;
            r_sfd_cnt  <= '0;
            r_data_cnt <= '0;
            r_tx_data  <= IDLE_CODE;
            r_tx_ctrl  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_sfd_cnt  <= w_sfd_cnt_nxt;
            r_data_cnt <= w_data_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_ctrl  <= w_tx_ctrl_nxt;
        end
    end

    // Next-state selection; start only matters once the idle gap is met.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start && (r_idle_cnt >= IDLE_LAST)) w_state_nxt = S_PREAMBLE;
            S_PREAMBLE: if (r_pre_cnt == PRE_LAST)               w_state_nxt = S_SFD;
            S_SFD:      if (r_sfd_cnt == SFD_LAST)               w_state_nxt = S_DATA;
            S_DATA:     if (r_data_cnt == DATA_LAST)             w_state_nxt = S_EOF;
            S_EOF:                                               w_state_nxt = S_IDLE;
            default:                                             w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counters count cycles spent in the state being entered; they
    // restart at zero on every state entry, so the payload index restarts per frame.
    always_comb begin
        w_idle_cnt_nxt = '0;
        w_pre_cnt_nxt  = '0;
        w_sfd_cnt_nxt  = '0;
        w_data_cnt_nxt = '0;
        if (r_state == S_IDLE && w_state_nxt == S_IDLE && r_idle_cnt != IDLE_MAX)
            w_idle_cnt_nxt = r_idle_cnt + IW'(1);
        else if (r_state == S_IDLE && w_state_nxt == S_IDLE)
            w_idle_cnt_nxt = r_idle_cnt;
        if (r_state == S_PREAMBLE && w_state_nxt == S_PREAMBLE)
            w_pre_cnt_nxt = r_pre_cnt + PW'(1);
        if (r_state == S_SFD && w_state_nxt == S_SFD)
            w_sfd_cnt_nxt = r_sfd_cnt + SW'(1);
        if (r_state == S_DATA && w_state_nxt == S_DATA)
            w_data_cnt_nxt = r_data_cnt + DW'(1);
    end

    // Output values for the state being entered, registered alongside it.
    always_comb begin
        w_tx_data_nxt = IDLE_CODE;
        w_tx_ctrl_nxt = 1'b0;
        case (w_state_nxt)
            S_PREAMBLE: begin
                w_tx_data_nxt = PREAMBLE_CODE;
                w_tx_ctrl_nxt = 1'b1;
            end
            S_SFD: begin
                w_tx_data_nxt = SFD_CODE;
                w_tx_ctrl_nxt = 1'b1;
            end
            S_DATA: begin
                w_tx_data_nxt = 8'(w_data_cnt_nxt);
                w_tx_ctrl_nxt = 1'b1;
            end
            S_EOF: begin
                w_tx_data_nxt = EOF_CODE;
                w_tx_ctrl_nxt = 1'b0;
            end
            default: begin
                w_tx_data_nxt = IDLE_CODE;
                w_tx_ctrl_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ethernet_frame_generator.sv
// Directed bench for ethernet_frame_generator: default instance plus an
// instance with longer payload, shorter preamble and a different preamble code.
module tb_ethernet_frame_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       tx_ctrl;
    logic       tx_clk;

    logic       rst_p;
    logic       start_p;
    logic [7:0] p_data;
    logic       p_ctrl;
    logic       p_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit use_p    = 1'b0;

    always #5 clk = ~clk;

    ethernet_frame_generator dut (
        .clk     (clk),
        .reset   (rst),
        .start   (start),
        .tx_data (tx_data),
        .tx_ctrl (tx_ctrl),
        .tx_clk  (tx_clk)
    );

    ethernet_frame_generator #(
        .PREAMBLE_CYCLES (3),
        .DATA_CYCLES     (300),
        .PREAMBLE_CODE   (8'hAA)
    ) dut_p (
        .clk     (clk),
        .reset   (rst_p),
        .start   (start_p),
        .tx_data (p_data),
        .tx_ctrl (p_ctrl),
        .tx_clk  (p_clk)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] ed, input logic ec);
        @(posedge clk);
        #1;
        if (use_p) begin
            chk({tag, "_data"}, 32'(p_data), 32'(ed));
            chk({tag, "_ctrl"}, 32'(p_ctrl), 32'(ec));
        end else begin
            chk({tag, "_data"}, 32'(tx_data), 32'(ed));
            chk({tag, "_ctrl"}, 32'(tx_ctrl), 32'(ec));
        end
    endtask

    task automatic step_idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 8'h00, 1'b0);
    endtask

    // Checks one frame from its first preamble byte; start drops after
    // drop_after sampled cycles (never if negative).
    task automatic frame(input int pre_n, input logic [7:0] pre_code, input int data_n,
                         input bit with_eof, input int drop_after);
        int k;
        k = 0;
        for (int i = 0; i < pre_n; i++) begin
            step("pre", pre_code, 1'b1);
            k++;
            if (k == drop_after) begin start = 1'b0; start_p = 1'b0; end
        end
        step("sfd", 8'hD5, 1'b1);
        k++;
        if (k == drop_after) begin start = 1'b0; start_p = 1'b0; end
        for (int i = 0; i < data_n; i++) begin
            step("payload", 8'(i), 1'b1);
            k++;
            if (k == drop_after) begin start = 1'b0; start_p = 1'b0; end
        end
        if (with_eof) step("eof", 8'h00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        rst_p   = 1'b1;
        start_p = 1'b0;

        // 1: reset held two cycles, then a long idle stretch
        step_idle(2);
        chk("txclk_high", 32'(tx_clk), 1);
        @(negedge clk);
        #1;
        chk("txclk_low", 32'(tx_clk), 0);
        chk("txclk_low_p", 32'(p_clk), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_idle(30);
        chk("txclk_run", 32'(tx_clk), 1);

        // 2: single frame after a fresh reset, start dropped mid-frame
        rst = 1'b1;
        step_idle(2);
        rst = 1'b0;
        step_idle(2);
        start = 1'b1;
        step_idle(9);
        frame(7, 8'h55, 46, 1'b1, 11);
        step_idle(20);

        // 3: start held high, back-to-back frames with a 12-cycle gap
        start = 1'b1;
        frame(7, 8'h55, 46, 1'b1, -1);
        step_idle(12);
        frame(7, 8'h55, 46, 1'b1, -1);
        step_idle(12);
        frame(7, 8'h55, 46, 1'b1, 1);

        // 4: pulse in idle cycle 5 is ignored, pulse in idle cycle 12 starts a frame
        step_idle(5);
        start = 1'b1;
        step_idle(1);
        start = 1'b0;
        step_idle(6);
        start = 1'b1;
        frame(7, 8'h55, 46, 1'b1, 1);

        // 5: reset during payload byte 20 aborts at once; full gap afterwards
        start = 1'b1;
        step_idle(12);
        frame(7, 8'h55, 21, 1'b0, -1);
        rst = 1'b1;
        #1;
        chk("abort_data", 32'(tx_data), 0);
        chk("abort_ctrl", 32'(tx_ctrl), 0);
        step_idle(2);
        rst = 1'b0;
        step_idle(11);
        frame(7, 8'h55, 46, 1'b1, 1);
        step_idle(14);

        // 6: overridden instance, payload wraps past 8'hFF
        use_p   = 1'b1;
        rst_p   = 1'b0;
        start_p = 1'b1;
        step_idle(11);
        frame(3, 8'hAA, 300, 1'b1, 1);
        step_idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
